// File: rtl/dmem_pkg.sv
// ----------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the data-memory responder slice.
//   state_t : responder FSM states (IDLE, WAIT, RESP)
//   WORD_W  : data word width (32)
//   BE_W    : number of byte lanes per word (4)
//   LAT_W   : width of the wait-state counter (4 bits, covers 0..15)
// ----------------------------------------------------------------------------
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;
    localparam int LAT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// ----------------------------------------------------------------------------
// dmem_responder_if
// Load/store request and response handshake between the processor and the
// data-memory responder.
//   req_valid/req_ready : request handshake (processor -> memory)
//   req_we              : 1 = store, 0 = load
//   req_addr            : byte address
//   req_wdata/req_be    : store data and byte-lane enables
//   resp_valid/resp_ready : response handshake (memory -> processor)
//   resp_rdata          : load data (0 for stores)
//   resp_err            : error flag
// Modports: slave = memory side, master = processor side.
// ----------------------------------------------------------------------------
interface dmem_responder_if;
    import dmem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [WORD_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              resp_valid;
    logic              resp_ready;
    logic [WORD_W-1:0] resp_rdata;
    logic              resp_err;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_byte_ram.sv
// ----------------------------------------------------------------------------
// dmem_byte_ram
// DEPTH x 32-bit storage with per-byte-lane write enables, synchronous write
// and a registered read port. Contents are never reset.
//   clk   : clock, rising edge
//   we    : write strobe; lanes selected by be are written at idx
//   be    : byte-lane enables, bit i covers wdata[8i+7:8i]
//   re    : read strobe; mem[idx] is captured into rdata
//   idx   : word index
//   wdata : write data
//   rdata : registered read data, holds until the next read strobe
// ----------------------------------------------------------------------------
module dmem_byte_ram
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [BE_W-1:0]          be,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [WORD_W-1:0]        wdata,
    output logic [WORD_W-1:0]        rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
// Memory end of the processor's data-access handshake. Accepts one request
// at a time, performs a byte-enabled word store or a word load on the accept
// edge, waits LAT_CYCLES wait states, then presents the response until the
// processor takes it.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : dmem_responder_if.slave (request/response handshake)
// Parameters:
//   DEPTH      : number of 32-bit words (power of 2, >= 4)
//   LAT_CYCLES : wait states between accept and response (0..15)
// Optional build macro:
//   DMEM_ERR_EN : flag misaligned or out-of-range accesses on resp_err,
//                 suppressing the store / zeroing the load data. Without it
//                 resp_err is 0 and addresses wrap modulo the array size.
// ----------------------------------------------------------------------------
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH      = 256,
    parameter int LAT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [LAT_W-1:0] LAT_LOAD =
        (LAT_CYCLES > 0) ? LAT_W'(LAT_CYCLES - 1) : '0;

    state_t            state;
    state_t            state_nx;
    logic [LAT_W-1:0]  cnt;
    logic              accept;
    logic              addr_err;
    logic              load_q;
    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] ram_rdata;

    assign accept = (state == IDLE) && bus.req_valid;
    assign idx    = bus.req_addr[IDX_W+1:2];

`ifdef DMEM_ERR_EN
    logic err_q;

    // Anything outside [0, 4*DEPTH) or not word aligned is rejected.
    assign addr_err = (bus.req_addr[1:0] != 2'b00) ||
                      (bus.req_addr[WORD_W-1:IDX_W+2] != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= addr_err;
        end else if (state == RESP && bus.resp_ready) begin
            err_q <= 1'b0;
        end
    end

    assign bus.resp_err = err_q;
`else
    assign addr_err     = 1'b0;
    assign bus.resp_err = 1'b0;
`endif

    // Storage is touched only on the accept edge; a rejected request neither
    // writes nor reads.
    dmem_byte_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (accept && bus.req_we && !addr_err),
        .be    (bus.req_be),
        .re    (accept && !bus.req_we && !addr_err),
        .idx   (idx),
        .wdata (bus.req_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = (LAT_CYCLES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Wait-state counter: loaded on accept, counts down to 0 in WAIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= LAT_LOAD;
        end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - LAT_W'(1);
        end
    end

    // load_q selects the RAM's held read word onto resp_rdata; stores and
    // rejected loads leave it clear so the response data reads as 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_q <= 1'b0;
        end else if (accept) begin
            load_q <= !bus.req_we && !addr_err;
        end else if (state == RESP && bus.resp_ready) begin
            load_q <= 1'b0;
        end
    end

    // All outputs come from registered state only.
    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = load_q ? ram_rdata : '0;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder that answers the RISC_V_Processor load/store request port; it is the memory end of the processor's data-access handshake. It accepts one request at a time and performs a byte-enabled word write or a word read against an internal array. After a programmable wait-state delay it returns a response with a valid/ready handshake. It replaces the zero-latency data memory in multi-cycle and pipelined builds, so stall logic can be exercised.

Parameters:
DEPTH, 256, number of 32-bit words; power of 2, minimum 4.
LAT_CYCLES, 2, wait states between request accept and response; 0..15.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
req_valid  in  1  processor request valid.
req_ready  out  1  responder can accept a request.
req_we  in  1  1 = store, 0 = load.
req_addr  in  32  byte address.
req_wdata  in  32  store data.
req_be  in  4  byte lane enables; bit i controls wdata[8i+7:8i].
resp_valid  out  1  response valid.
resp_ready  in  1  processor accepts the response.
resp_rdata  out  32  load data; 0 for stores.
resp_err  out  1  error flag; constant 0 unless DMEM_ERR_EN is defined.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, req_ready=1 after release, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0. Array contents are not reset.
- FSM states:
  - IDLE: req_ready=1. On req_valid at an edge the request is accepted. Next state is WAIT when LAT_CYCLES>0, otherwise RESP.
  - WAIT: counter is loaded with LAT_CYCLES-1 on accept and decrements each cycle. The state moves to RESP on the edge where counter==0.
  - RESP: resp_valid=1. resp_rdata and resp_err are held stable until resp_ready=1 at an edge, then the state returns to IDLE.
- req_ready=1 only in IDLE. A request arriving in WAIT or RESP is not accepted, and the processor must hold it.
- Latency: resp_valid rises exactly LAT_CYCLES+1 cycles after the accept edge. Minimum transaction is 2 cycles (accept, then respond), which gives throughput of 1 transaction per 2 cycles when LAT_CYCLES=0 and resp_ready=1.
- Array access happens on the accept edge:
  - Word index = req_addr[log2(DEPTH)+1:2]; upper address bits and req_addr[1:0] are ignored.
  - Store: only lanes with req_be set are written. resp_rdata is registered as 0.
  - Load: the full word is registered into resp_rdata. req_be is ignored.
- A store is visible to the next request (read-after-write is ordered). A load of the same word returns the new data.
- A store with req_be=0 writes nothing and still produces a normal response.
- Index wrap: address 4*DEPTH aliases word 0.
- resp_ready held 1 before resp_valid: there is no effect until RESP, and then the state completes in one cycle.
- Reset asserted in WAIT or RESP: the transaction is abandoned and no response is issued. A store already committed on its accept edge remains written.
- No combinational path from req_* to resp_*, and none from resp_ready to req_ready.

Optional Feature:
DMEM_ERR_EN
- Defined:
  - The accept edge flags an error when req_addr[1:0]!=0 with a store or load, or when req_addr >= 4*DEPTH.
  - An erroring store performs no write. An erroring load returns resp_rdata=0.
  - resp_err=1 with the response. Latency and handshake are unchanged.
- Undefined: resp_err is tied to 0, and address wrap/ignore rules apply as above.

Decomposition:
- Package dmem_pkg contains:
  - state enum (IDLE, WAIT, RESP);
  - WORD_W=32, BE_W=4;
  - LAT counter width constant of 4 bits.
- One sub-module, dmem_byte_ram: DEPTH x 32 array with a per-lane write enable, synchronous write, and a registered read. The FSM, counter, and error check stay in dmem_responder.

Test Plan:
- LAT_CYCLES=2: store addr 0x10, wdata 0xDEADBEEF, be 0xF, then load 0x10 -> load resp_valid exactly 3 cycles after its accept, resp_rdata 0xDEADBEEF, resp_err 0.
- Partial write: store 0x11223344 to 0x20, then store 0xAABBCCDD with be 0b0101 -> load 0x20 returns 0x11BB33DD.
- Backpressure: hold resp_ready=0 for 5 cycles during a load response -> resp_valid and resp_rdata stay constant and req_ready=0; with a new req_valid held, it is accepted the cycle after resp_ready=1.
- LAT_CYCLES=0 back-to-back loads with resp_ready=1 -> one response every 2 cycles, with req_ready alternating 1/0.
- Reset pulse (reset=0 for 3 cycles) during WAIT of a load -> resp_valid never asserts, state IDLE, req_ready=1 after release.
- DMEM_ERR_EN, DEPTH=256: load 0x402 and store to 0x400 -> resp_err=1, resp_rdata 0, and the word at index 0 is unchanged. Without the macro, a store to 0x400 overwrites word 0.
